unified_mem_ctrl: RTL

- Single-ported unified word memory with request/ready handshakes for the multicycle MIPS core.
- Sits directly downstream of the core and replaces its separate instruction/data memories.
- Arbitrates between an instruction-fetch port (read-only) and a data port (read/write, byte enables).
- Models a fixed access latency so the control FSM must stall on ready.

---
 rtl/unified_mem_ctrl_if.sv | 40 ++++
 rtl/unified_mem_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/unified_mem_ctrl_if.sv
// Request/ready bus between the multicycle core (master) and the unified memory (slave).
// Optional macro MEM_MISALIGN_CHK_EN adds the if_err/d_err completion flags.
interface unified_mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        busy;
`ifdef MEM_MISALIGN_CHK_EN
    logic        if_err;
    logic        d_err;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_rdata, if_ready, d_rdata, d_ready, busy, if_err, d_err
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_rdata, if_ready, d_rdata, d_ready, busy, if_err, d_err
    );
`else
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_rdata, if_ready, d_rdata, d_ready, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_rdata, if_ready, d_rdata, d_ready, busy
    );
`endif
endinterface

// File: rtl/unified_mem_ctrl.sv
// Single-ported unified word memory shared by the fetch port and the data port.
// Round-robin arbitration on contention, fixed LATENCY from accept to ready.
// Optional macro MEM_MISALIGN_CHK_EN: misaligned accesses complete with err and no effect.
module unified_mem_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic               clk,
    input logic               rst,
    unified_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic PortFetch = 1'b0;
    localparam logic PortData  = 1'b1;
    localparam int unsigned Depth = 2 ** ADDR_W;

    state_e            state_q;
    logic              port_q;
    logic              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [3:0]        be_q;
    logic [3:0]        cnt_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic [31:0]       mem_q [Depth];

    logic              grant_data;
    logic              access;
    logic              mem_we;
    logic              misaligned;
    logic [31:0]       rd_word;

    // On contention the port that did not win last time gets the grant.
    assign grant_data = bus.d_req & (~bus.if_req | (last_grant_q == PortFetch));
    assign access     = (state_q == StWait) && (cnt_q == 4'd0);

`ifdef MEM_MISALIGN_CHK_EN
    logic misaligned_q;
    logic if_err_q;
    logic d_err_q;
    logic grant_mis;
    logic unused_addr;

    assign grant_mis   = grant_data ? (bus.d_addr[1:0] != 2'b00) : (bus.if_addr[1:0] != 2'b00);
    assign misaligned  = misaligned_q;
    assign bus.if_err  = if_err_q;
    assign bus.d_err   = d_err_q;
    assign unused_addr = ^{bus.if_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};
`else
    logic unused_addr;

    assign misaligned  = 1'b0;
    assign unused_addr = ^{bus.if_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2],
                           bus.if_addr[1:0], bus.d_addr[1:0]};
`endif

    assign mem_we  = access & (port_q == PortData) & we_q & ~misaligned;
    // A misaligned access returns zero instead of the addressed word.
    assign rd_word = misaligned ? 32'd0 : mem_q[idx_q];

    assign bus.if_rdata = if_rdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.busy     = (state_q != StIdle);

    // Byte-masked memory write; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && be_q[i]) begin
                mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // Control FSM: grant and latch the request, count latency, complete with a ready pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            port_q       <= PortFetch;
            last_grant_q <= PortFetch;
            we_q         <= 1'b0;
            idx_q        <= '0;
            be_q         <= 4'd0;
            cnt_q        <= 4'd0;
            wdata_q      <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
            misaligned_q <= 1'b0;
            if_err_q     <= 1'b0;
            d_err_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.if_req || bus.d_req) begin
                        port_q       <= grant_data;
                        last_grant_q <= grant_data;
                        idx_q        <= grant_data ? bus.d_addr[ADDR_W+1:2]
                                                   : bus.if_addr[ADDR_W+1:2];
                        we_q         <= grant_data & bus.d_we;
                        be_q         <= bus.d_be;
                        wdata_q      <= bus.d_wdata;
                        cnt_q        <= 4'(LATENCY - 1);
`ifdef MEM_MISALIGN_CHK_EN
                        misaligned_q <= grant_mis;
`endif
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (port_q == PortData) begin
                            d_ready_q <= 1'b1;
                            // A misaligned write still clears d_rdata.
                            if (!we_q || misaligned) begin
                                d_rdata_q <= rd_word;
                            end
`ifdef MEM_MISALIGN_CHK_EN
                            d_err_q <= misaligned_q;
`endif
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= rd_word;
`ifdef MEM_MISALIGN_CHK_EN
                            if_err_q   <= misaligned_q;
`endif
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
                    if_err_q   <= 1'b0;
                    d_err_q    <= 1'b0;
`endif
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
